// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the Hydra integer datapath.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and decodes datapath
// strobes from the current state and the captured instruction word.
module multicycle_ctrl #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             imem_valid,
   output logic             imem_ready,
   input  logic [31:0]      ins,
   input  logic             br_taken,
   input  logic             dmem_ack,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             ir_we,
   output logic             alu_src_imm,
   output logic [3:0]       alu_ctl,
   output logic             reg_we,
   output logic             wb_sel,
   output logic             pc_we,
   output logic             pc_sel,
   output logic             illegal,
   output logic             bus_err,
   output logic [CNT_W-1:0] retire_cnt
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   localparam logic [6:0] OPC_OPIMM  = 7'd19;
   localparam logic [6:0] OPC_OP     = 7'd51;
   localparam logic [6:0] OPC_LOAD   = 7'd3;
   localparam logic [6:0] OPC_STORE  = 7'd35;
   localparam logic [6:0] OPC_BRANCH = 7'd99;

   localparam int unsigned     TO_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

   state_t          state, state_nxt;
   logic [31:0]     ir;
   logic [TO_W-1:0] to_cnt;
   logic            to_clr, to_inc;
   logic            set_illegal, set_bus_err;
   logic            legal;
   logic [3:0]      alu_ctl_dec;
   logic            unused_ir_bits;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       is_opimm, is_op, is_load, is_store, is_branch;

   assign opcode    = ir[6:0];
   assign funct3    = ir[14:12];
   assign funct7    = ir[31:25];
   assign is_opimm  = (opcode == OPC_OPIMM);
   assign is_op     = (opcode == OPC_OP);
   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_branch = (opcode == OPC_BRANCH);

   // Register specifiers and immediates are consumed by the datapath, not here.
   assign unused_ir_bits = ^{ir[24:15], ir[11:7]};

   // Instruction legality from opcode, funct3 and funct7
   always_comb begin
      legal = 1'b0;
      unique case (1'b1)
         is_opimm: begin
            if (funct3 == 3'd1)      legal = (funct7 == 7'b0000000);
            else if (funct3 == 3'd5) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            else                     legal = 1'b1;
         end
         is_op:     legal = (funct7 == 7'b0000000) ||
                            ((funct7 == 7'b0100000) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
         is_load:   legal = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
         is_store:  legal = (funct3 <= 3'd2);
         is_branch: legal = (funct3 != 3'd2) && (funct3 != 3'd3);
         default:   legal = 1'b0;
      endcase
   end

   // ALU operation selected by instruction class
   always_comb begin
      alu_ctl_dec = '0;
      if (is_op)          alu_ctl_dec = {ir[30], funct3};
      else if (is_opimm)  alu_ctl_dec = {(funct3 == 3'd5) & ir[30], funct3};
      else if (is_branch) alu_ctl_dec = 4'b1000;
   end

   // Next-state and strobe decode
   always_comb begin
      state_nxt   = state;
      imem_ready  = 1'b0;
      ir_we       = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      alu_src_imm = 1'b0;
      alu_ctl     = '0;
      reg_we      = 1'b0;
      wb_sel      = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = 1'b0;
      to_clr      = 1'b0;
      to_inc      = 1'b0;
      set_illegal = 1'b0;
      set_bus_err = 1'b0;
      unique case (state)
         S_FETCH: begin
            imem_ready = 1'b1;
            ir_we      = imem_valid;
            if (imem_valid) state_nxt = S_DECODE;
         end
         S_DECODE: begin
            if (legal) begin
               state_nxt = S_EXEC;
            end else begin
               set_illegal = 1'b1;
               state_nxt   = S_TRAP;
            end
         end
         S_EXEC: begin
            alu_src_imm = is_opimm | is_load | is_store;
            alu_ctl     = alu_ctl_dec;
            if (is_branch) begin
               pc_we     = 1'b1;
               pc_sel    = br_taken;
               state_nxt = S_FETCH;
            end else if (is_op || is_opimm) begin
               state_nxt = S_WB;
            end else if (is_load || is_store) begin
               to_clr    = 1'b1;
               state_nxt = S_MEM;
            end else begin
               state_nxt = S_TRAP;
            end
         end
         S_MEM: begin
            dmem_req    = 1'b1;
            dmem_we     = is_store;
            alu_src_imm = 1'b1;
            alu_ctl     = alu_ctl_dec;
            // ack is tested before expiry so a last-cycle ack still completes
            if (dmem_ack) begin
               if (is_store) begin
                  pc_we     = 1'b1;
                  state_nxt = S_FETCH;
               end else begin
                  state_nxt = S_WB;
               end
            end else if (to_cnt == TO_LAST) begin
               set_bus_err = 1'b1;
               state_nxt   = S_TRAP;
            end else begin
               to_inc = 1'b1;
            end
         end
         S_WB: begin
            reg_we    = 1'b1;
            wb_sel    = is_load;
            pc_we     = 1'b1;
            state_nxt = S_FETCH;
         end
         S_TRAP: state_nxt = S_TRAP;
         default: state_nxt = S_TRAP;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_nxt;
   end

   // Instruction register capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     ir <= '0;
      else if (ir_we) ir <= ins;
   end

   // MEM wait-cycle counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      to_cnt <= '0;
      else if (to_clr) to_cnt <= '0;
      else if (to_inc) to_cnt <= to_cnt + TO_W'(1);
   end

   // Sticky trap flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         if (set_illegal) illegal <= 1'b1;
         if (set_bus_err) bus_err <= 1'b1;
      end
   end

   // Retired-instruction counter, one count per PC update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     retire_cnt <= '0;
      else if (pc_we) retire_cnt <= retire_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_valid;
   logic        imem_ready;
   logic [31:0] ins;
   logic        br_taken;
   logic        dmem_ack;
   logic        dmem_req;
   logic        dmem_we;
   logic        ir_we;
   logic        alu_src_imm;
   logic [3:0]  alu_ctl;
   logic        reg_we;
   logic        wb_sel;
   logic        pc_we;
   logic        pc_sel;
   logic        illegal;
   logic        bus_err;
   logic [31:0] retire_cnt;
   logic [14:0] outs;

   int total = 0;
   int bad   = 0;

   multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_valid (imem_valid),
      .imem_ready (imem_ready),
      .ins        (ins),
      .br_taken   (br_taken),
      .dmem_ack   (dmem_ack),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .ir_we      (ir_we),
      .alu_src_imm(alu_src_imm),
      .alu_ctl    (alu_ctl),
      .reg_we     (reg_we),
      .wb_sel     (wb_sel),
      .pc_we      (pc_we),
      .pc_sel     (pc_sel),
      .illegal    (illegal),
      .bus_err    (bus_err),
      .retire_cnt (retire_cnt)
   );

   always #5 clk = ~clk;

   // {imem_ready, ir_we, dmem_req, dmem_we, alu_src_imm, alu_ctl[3:0],
   //  reg_we, wb_sel, pc_we, pc_sel, illegal, bus_err}
   assign outs = {imem_ready, ir_we, dmem_req, dmem_we, alu_src_imm, alu_ctl,
                  reg_we, wb_sel, pc_we, pc_sel, illegal, bus_err};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // OP / OP-IMM instruction from FETCH through WB back to FETCH
   task automatic run_alu(input string nm, input logic [31:0] word, input logic [3:0] ctl,
                          input logic imm, input logic [31:0] rc);
      ins = word;
      imem_valid = 1'b1;
      tick();
      imem_valid = 1'b0;
      tick();
      chk({nm, "_e_ctl"}, 32'(alu_ctl), 32'(ctl));
      chk({nm, "_e_imm"}, 32'(alu_src_imm), 32'(imm));
      tick();
      chk({nm, "_wb"}, 32'({reg_we, wb_sel, pc_we, pc_sel}), 32'b1010);
      tick();
      chk({nm, "_f_ready"}, 32'(imem_ready), 1);
      chk({nm, "_retire"}, retire_cnt, rc + 1);
   endtask

   initial begin
      rst_n = 1'b0; imem_valid = 1'b0; ins = '0; br_taken = 1'b0; dmem_ack = 1'b0;
      #12;
      chk("reset_outs", 32'(outs), 32'h4000);
      chk("reset_retire", retire_cnt, 0);
      rst_n = 1'b1;

      // addi x1,x0,5 with imem_valid held
      ins = 32'h00500093; imem_valid = 1'b1;
      #1;
      chk("addi_f_irwe", 32'(ir_we), 1);
      tick();
      chk("addi_d_ready", 32'(imem_ready), 0);
      chk("addi_d_irwe", 32'(ir_we), 0);
      tick();
      chk("addi_e_imm", 32'(alu_src_imm), 1);
      chk("addi_e_ctl", 32'(alu_ctl), 0);
      chk("addi_e_regwe", 32'(reg_we), 0);
      chk("addi_e_ready", 32'(imem_ready), 0);
      tick();
      chk("addi_wb", 32'({reg_we, wb_sel, pc_we, pc_sel}), 32'b1010);
      chk("addi_wb_retire", retire_cnt, 0);
      imem_valid = 1'b0;
      tick();
      chk("addi_f5_ready", 32'(imem_ready), 1);
      chk("addi_retire", retire_cnt, 1);
      tick();
      chk("idle_stay_ready", 32'(imem_ready), 1);

      // lw x2,4(x1), ack on third MEM cycle
      ins = 32'h0040A103; imem_valid = 1'b1;
      tick();
      imem_valid = 1'b0;
      tick();
      chk("lw_e_imm", 32'(alu_src_imm), 1);
      chk("lw_e_req", 32'(dmem_req), 0);
      tick();
      chk("lw_m1", 32'({dmem_req, dmem_we}), 32'b10);
      tick();
      chk("lw_m2", 32'({dmem_req, dmem_we, pc_we}), 32'b100);
      tick();
      dmem_ack = 1'b1;
      #1;
      chk("lw_m3", 32'({dmem_req, dmem_we, pc_we, reg_we, alu_src_imm}), 32'b10001);
      tick();
      dmem_ack = 1'b0;
      chk("lw_wb", 32'({reg_we, wb_sel, pc_we, pc_sel, dmem_req}), 32'b11100);
      tick();
      chk("lw_f_ready", 32'(imem_ready), 1);
      chk("lw_retire", retire_cnt, 2);

      // sw x2,8(x1), ack on first MEM cycle
      ins = 32'h0020A423; imem_valid = 1'b1;
      tick();
      imem_valid = 1'b0;
      tick();
      chk("sw_e", 32'({alu_src_imm, reg_we}), 32'b10);
      tick();
      dmem_ack = 1'b1;
      #1;
      chk("sw_m1", 32'({dmem_req, dmem_we, pc_we, pc_sel, reg_we}), 32'b11100);
      tick();
      dmem_ack = 1'b0;
      chk("sw_f", 32'({imem_ready, dmem_req}), 32'b10);
      chk("sw_retire", retire_cnt, 3);

      // beq x0,x0,8 taken then not taken
      ins = 32'h00000463; imem_valid = 1'b1;
      tick();
      imem_valid = 1'b0;
      tick();
      br_taken = 1'b1;
      #1;
      chk("beq_t_e", 32'({alu_ctl, alu_src_imm, pc_we, pc_sel}), 32'b1000011);
      tick();
      br_taken = 1'b0;
      chk("beq_t_f", 32'(imem_ready), 1);
      chk("beq_t_retire", retire_cnt, 4);
      imem_valid = 1'b1;
      tick();
      imem_valid = 1'b0;
      tick();
      chk("beq_n_e", 32'({alu_ctl, alu_src_imm, pc_we, pc_sel}), 32'b1000010);
      tick();
      chk("beq_n_f", 32'(imem_ready), 1);
      chk("beq_n_retire", retire_cnt, 5);

      // ALU variants: sub, srai, addi with negative immediate
      run_alu("sub",  32'h402081B3, 4'b1000, 1'b0, 5);
      run_alu("srai", 32'h4010D093, 4'b1101, 1'b1, 6);
      run_alu("addn", 32'hFFF00093, 4'b0000, 1'b1, 7);

      // Illegal opcode 0x7F
      ins = 32'h0000007F; imem_valid = 1'b1;
      tick();
      chk("ill_d_flag", 32'(illegal), 0);
      tick();
      chk("ill_trap_outs", 32'(outs), 32'h0002);
      chk("ill_trap_retire", retire_cnt, 8);
      tick();
      chk("ill_trap_stay", 32'(outs), 32'h0002);
      imem_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("ill_rst_outs", 32'(outs), 32'h4000);
      chk("ill_rst_retire", retire_cnt, 0);
      #2 rst_n = 1'b1;

      // slli with funct7=0100000 is illegal
      ins = 32'h40109093; imem_valid = 1'b1;
      tick();
      imem_valid = 1'b0;
      tick();
      chk("slli_trap_outs", 32'(outs), 32'h0002);
      chk("slli_retire", retire_cnt, 0);
      rst_n = 1'b0;
      #1;
      chk("slli_rst_outs", 32'(outs), 32'h4000);
      #2 rst_n = 1'b1;

      // Load with no ack: 16 request cycles then bus error
      ins = 32'h0040A103; imem_valid = 1'b1;
      tick();
      imem_valid = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("to_req_%0d", i), 32'({dmem_req, bus_err}), 32'b10);
         tick();
      end
      chk("to_trap_outs", 32'(outs), 32'h0001);
      chk("to_retire", retire_cnt, 0);
      rst_n = 1'b0;
      #1;
      chk("to_rst_outs", 32'(outs), 32'h4000);
      #2 rst_n = 1'b1;

      // Load acked on the 16th MEM cycle completes normally
      imem_valid = 1'b1;
      tick();
      imem_valid = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 15; i++) tick();
      dmem_ack = 1'b1;
      #1;
      chk("edge_m16", 32'({dmem_req, bus_err}), 32'b10);
      tick();
      dmem_ack = 1'b0;
      chk("edge_wb", 32'({reg_we, wb_sel, bus_err}), 32'b110);
      tick();
      chk("edge_f", 32'(imem_ready), 1);
      chk("edge_retire", retire_cnt, 1);

      // Reset asserted mid-MEM drops the request immediately
      imem_valid = 1'b1;
      tick();
      imem_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("mrst_m2_req", 32'(dmem_req), 1);
      rst_n = 1'b0;
      #1;
      chk("mrst_outs", 32'(outs), 32'h4000);
      chk("mrst_retire", retire_cnt, 0);
      #2 rst_n = 1'b1;
      tick();
      chk("mrst_after", 32'(imem_ready), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
